// File: rtl/router_out_arbiter.sv
// Output-port arbiter for the mesh router: round-robin grant with wormhole
// locking from head to tail flit, gated by credit-based downstream flow control.
module router_out_arbiter #(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned CREDITS = 4,
  localparam int unsigned SW     = $clog2(NREQ),
  localparam int unsigned CW     = $clog2(CREDITS + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [NREQ-1:0] valid_i,
  input  logic [NREQ-1:0] tail_i,
  output logic [NREQ-1:0] ready_o,
  output logic            out_valid_o,
  output logic [SW-1:0]   out_sel_o,
  input  logic            credit_i,
  output logic [CW-1:0]   credits_o,
  output logic            busy_o,
  output logic            ovf_o
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] owner_q, owner_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic [SW-1:0] pick_c;
  logic [SW-1:0] next_ptr_c;
  logic [CW-1:0] credits_q, credits_d;
  logic          ovf_q, ovf_d;
  logic          transfer_c;
  logic          found_c;
  int unsigned   idx_c;

  // Round-robin search: first requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    pick_c  = ptr_q;
    found_c = 1'b0;
    idx_c   = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx_c = (32'(ptr_q) + i) % NREQ;
      if (!found_c && valid_i[SW'(idx_c)]) begin
        found_c = 1'b1;
        pick_c  = SW'(idx_c);
      end
    end
  end

  assign next_ptr_c = (owner_q == SW'(NREQ - 1)) ? '0 : owner_q + SW'(1);
  assign transfer_c = (state_q == LOCKED) && valid_i[owner_q] && (credits_q != '0);

  // Next-state, ownership and pointer update.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (|valid_i) begin
          state_d = LOCKED;
          owner_d = pick_c;
        end
      end
      LOCKED: begin
        if (transfer_c && tail_i[owner_q]) begin
          state_d = IDLE;
          ptr_d   = next_ptr_c;
        end
      end
    endcase
  end

  // Credit bookkeeping; a return at the ceiling is dropped and flagged.
  always_comb begin
    credits_d = credits_q;
    ovf_d     = ovf_q;
    if (transfer_c && !credit_i) begin
      credits_d = credits_q - CW'(1);
    end else if (!transfer_c && credit_i) begin
      if (credits_q == CW'(CREDITS)) begin
        ovf_d = 1'b1;
      end else begin
        credits_d = credits_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      ptr_q     <= '0;
      credits_q <= CW'(CREDITS);
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      credits_q <= credits_d;
      ovf_q     <= ovf_d;
    end
  end

  assign ready_o     = transfer_c ? (NREQ'(1) << owner_q) : '0;
  assign out_valid_o = transfer_c;
  assign out_sel_o   = owner_q;
  assign busy_o      = (state_q == LOCKED);
  assign credits_o   = credits_q;
  assign ovf_o       = ovf_q;

endmodule

// File: doc/router_out_arbiter.md
# router_out_arbiter

Per-output-port arbiter and flow-control sequencer for the mesh router. It shares one output channel (NS, WE, diagonal or local) between the input ports whose route decode selects that output. It uses round-robin arbitration with wormhole locking: the owner holds the channel from head flit to tail flit. Credit-based flow control toward the downstream buffer gates every transfer. One instance sits in front of each output mux and drives that mux's select.

## Interface
Parameters:
- NREQ, 4, number of input ports competing for this output (≥2)
- CREDITS, 4, downstream buffer depth in flits; credit counter reset value and ceiling
- SW, $clog2(NREQ), width of owner select (derived, not overridden)
- CW, $clog2(CREDITS+1), width of credit counter (derived, not overridden)

Ports:
- clk_i  in  1  clock; all state changes on rising edge
- rst_i  in  1  reset, synchronous, active-high
- valid_i  in  NREQ  input port i has a flit routed to this output
- tail_i  in  NREQ  flit on port i is the packet's last flit (single-flit packet: tail on first flit)
- ready_o  out  NREQ  one-hot or zero; flit on port i is consumed this cycle
- out_valid_o  out  1  flit forwarded on output channel this cycle
- out_sel_o  out  SW  index of current owner; output mux select
- credit_i  in  1  one-cycle pulse, downstream freed one buffer slot
- credits_o  out  CW  current credit count
- busy_o  out  1  channel locked to an owner
- ovf_o  out  1  sticky: credit returned while counter at CREDITS

## Operation
- States: IDLE, LOCKED.
- IDLE: if any valid_i is set, round-robin pick starting at index ptr and wrapping modulo NREQ. First set bit wins. Register owner, go to LOCKED. No transfer in IDLE.
- LOCKED: transfer = valid_i[owner] && credits_o > 0.
  - ready_o[owner] = transfer; out_valid_o = transfer; all other ready_o bits 0.
- Transfer with tail_i[owner]: go to IDLE, ptr ← (owner+1) mod NREQ.
- Owner dropping valid_i mid-packet: stay LOCKED, no transfer; other requesters keep waiting.
- Requests from non-owners while LOCKED are ignored; no preemption.
- Credit counter: next = credits − transfer + credit_i.
  - credit_i at CREDITS with no transfer: counter holds, ovf_o set until reset.
  - Transfer with credit_i in the same cycle: counter unchanged.
  - At 0 credits no transfer occurs, so a credit_i in that cycle only increments; first transfer is the next cycle.
- out_sel_o = owner register; stable throughout LOCKED, holds last value in IDLE.
- busy_o = (state == LOCKED).

## Timing
- Reset values: state IDLE, ptr 0, owner 0, credits_o = CREDITS, ovf_o 0, busy_o 0, out_sel_o 0, ready_o 0, out_valid_o 0.
- Reset mid-packet: abandons the packet and restores credits to CREDITS. Upstream/downstream are reset together.
- Arbitration latency: valid_i sampled in IDLE cycle N → busy_o and out_sel_o valid in N+1. First flit transfers in N+1 if credits > 0.
- Throughput: one flit per cycle while the owner is valid and credits > 0.
- Packet gap: tail transfer in cycle T → IDLE in T+1 → next owner transfers at earliest T+2.
- ready_o and out_valid_o are combinational from valid_i and registered state. No combinational path exists from credit_i to ready_o.
- credits_o and ovf_o are registered; they reflect updates one cycle after the causing edge.

## Test plan
- Single packet: port 2 presents 3 flits (tail on the 3rd), NREQ=4, CREDITS=4. Required: busy_o=1 and out_sel_o=2 in cycle 1. ready_o=4'b0100 in cycles 1–3. IDLE in cycle 4. credits_o goes 4→1.
- Fairness: ports 0 and 3 both send continuous 1-flit packets, with credits returned each cycle. Required: grants alternate 0,3,0,3. A third requester, port 1, added mid-run is granted before port 3 repeats.
- Credit starvation: CREDITS=2, no credit_i, 4-flit packet. Required: 2 transfers, then ready_o=0 with busy_o=1. Then credit_i pulse in cycle K → transfer in K+1.
- Simultaneous events: credits_o=1 with transfer and credit_i in the same cycle → credits_o stays 1. credits_o=0 with credit_i → no transfer that cycle, credits_o=1 next cycle.
- Overflow and reset: at credits_o=CREDITS, pulse credit_i → ovf_o=1 and credits_o stays at CREDITS. Assert rst_i mid-packet → next cycle all outputs at reset values, ptr=0, ovf_o=0.
- Owner stall: owner drops valid_i for 3 cycles mid-packet while port 0 requests. Required: out_sel_o unchanged, ready_o=0 for those cycles, and port 0 is not granted until after the owner's tail.
